// File: rtl/occupancy_scheduler_if.sv
// Doorway sensor inputs, counter datapath handshake and status flags of the occupancy scheduler.
// master drives beams and counter value; slave is the scheduler.
interface occupancy_scheduler_if #(
    parameter int NDOORS = 4,
    parameter int CNT_W  = 8
);
    logic [NDOORS-1:0] outer;
    logic [NDOORS-1:0] inner;
    logic [CNT_W-1:0]  cnt;
    logic              add;
    logic              sub;
    logic [NDOORS-1:0] grant;
    logic              full;
    logic              err;

    modport master (
        output outer, inner, cnt,
        input  add, sub, grant, full, err
    );

    modport slave (
        input  outer, inner, cnt,
        output add, sub, grant, full, err
    );
endinterface

// File: rtl/occupancy_scheduler.sv
// Per-door passage decoding, pending entry/exit queues and round-robin arbitration
// for a single add/sub port of the occupancy counter datapath.
module occupancy_scheduler #(
    parameter int NDOORS = 4,
    parameter int CNT_W  = 8,
    parameter int CAP    = 200,
    parameter int PEND_W = 2
) (
    input logic                  clk,
    input logic                  rst,
    occupancy_scheduler_if.slave bus
);
    localparam int unsigned ND = NDOORS;
    localparam int          PW = $clog2(NDOORS);

    typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3} door_st_t;

    door_st_t          st_q   [NDOORS];
    door_st_t          st_d   [NDOORS];
    logic [PEND_W-1:0] pin_q  [NDOORS];
    logic [PEND_W-1:0] pin_d  [NDOORS];
    logic [PEND_W-1:0] pout_q [NDOORS];
    logic [PEND_W-1:0] pout_d [NDOORS];
    logic [NDOORS-1:0] ev_in, ev_out, elig, grant_c, gsel_in, gsel_out;
    logic [PW-1:0]     ptr_q, gnt_idx;
    logic              gnt_vld, gnt_exit, full_c, ovf, underflow, err_q;

    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int unsigned k);
        int unsigned s;
        s = 32'(base) + k;
        if (s >= ND) s = s - ND;
        return PW'(s);
    endfunction

    // Exit states mirror entry states with the beams swapped, so they test {inner,outer}.
    always_comb begin
        for (int unsigned d = 0; d < ND; d++) begin
            st_d[d]   = st_q[d];
            ev_in[d]  = 1'b0;
            ev_out[d] = 1'b0;
            case (st_q[d])
                IDLE: begin
                    if (bus.outer[d] && !bus.inner[d])      st_d[d] = EN1;
                    else if (!bus.outer[d] && bus.inner[d]) st_d[d] = EX1;
                end
                EN1: case ({bus.outer[d], bus.inner[d]})
                    2'b11:   st_d[d] = EN2;
                    2'b00:   st_d[d] = IDLE;
                    2'b01:   st_d[d] = EX1;
                    default: st_d[d] = EN1;
                endcase
                EN2: case ({bus.outer[d], bus.inner[d]})
                    2'b01:   st_d[d] = EN3;
                    2'b10:   st_d[d] = EN1;
                    2'b00:   st_d[d] = IDLE;
                    default: st_d[d] = EN2;
                endcase
                EN3: case ({bus.outer[d], bus.inner[d]})
                    2'b00:   begin st_d[d] = IDLE; ev_in[d] = 1'b1; end
                    2'b11:   st_d[d] = EN2;
                    2'b10:   st_d[d] = EN1;
                    default: st_d[d] = EN3;
                endcase
                EX1: case ({bus.inner[d], bus.outer[d]})
                    2'b11:   st_d[d] = EX2;
                    2'b00:   st_d[d] = IDLE;
                    2'b01:   st_d[d] = EN1;
                    default: st_d[d] = EX1;
                endcase
                EX2: case ({bus.inner[d], bus.outer[d]})
                    2'b01:   st_d[d] = EX3;
                    2'b10:   st_d[d] = EX1;
                    2'b00:   st_d[d] = IDLE;
                    default: st_d[d] = EX2;
                endcase
                EX3: case ({bus.inner[d], bus.outer[d]})
                    2'b00:   begin st_d[d] = IDLE; ev_out[d] = 1'b1; end
                    2'b11:   st_d[d] = EX2;
                    2'b10:   st_d[d] = EX1;
                    default: st_d[d] = EX3;
                endcase
                default: st_d[d] = IDLE;
            endcase
        end
    end

    always_comb begin
        full_c = (bus.cnt >= CNT_W'(CAP));
        for (int unsigned d = 0; d < ND; d++) begin
            elig[d] = (pout_q[d] != '0) || ((pin_q[d] != '0) && !full_c);
        end
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int unsigned k = 0; k < ND; k++) begin
            if (!gnt_vld && elig[wrap_idx(ptr_q, k)]) begin
                gnt_vld = 1'b1;
                gnt_idx = wrap_idx(ptr_q, k);
            end
        end
        gnt_exit  = gnt_vld && (pout_q[gnt_idx] != '0);
        grant_c   = gnt_vld ? (NDOORS'(1) << gnt_idx) : '0;
        gsel_in   = gnt_exit ? '0 : grant_c;
        gsel_out  = gnt_exit ? grant_c : '0;
        underflow = gnt_exit && (bus.cnt == '0);
    end

    // A simultaneous event and grant on one counter cancel; saturation drops the event.
    always_comb begin
        ovf = 1'b0;
        for (int unsigned d = 0; d < ND; d++) begin
            pin_d[d]  = pin_q[d];
            pout_d[d] = pout_q[d];
            if (ev_in[d] && !gsel_in[d]) begin
                if (&pin_q[d]) ovf = 1'b1;
                else           pin_d[d] = pin_q[d] + 1'b1;
            end else if (!ev_in[d] && gsel_in[d]) begin
                pin_d[d] = pin_q[d] - 1'b1;
            end
            if (ev_out[d] && !gsel_out[d]) begin
                if (&pout_q[d]) ovf = 1'b1;
                else            pout_d[d] = pout_q[d] + 1'b1;
            end else if (!ev_out[d] && gsel_out[d]) begin
                pout_d[d] = pout_q[d] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned d = 0; d < ND; d++) begin
                st_q[d]   <= IDLE;
                pin_q[d]  <= '0;
                pout_q[d] <= '0;
            end
            ptr_q <= '0;
            err_q <= 1'b0;
        end else begin
            for (int unsigned d = 0; d < ND; d++) begin
                st_q[d]   <= st_d[d];
                pin_q[d]  <= pin_d[d];
                pout_q[d] <= pout_d[d];
            end
            if (gnt_vld) ptr_q <= wrap_idx(gnt_idx, 1);
            err_q <= err_q | ovf | underflow;
        end
    end

    always_comb begin
        bus.grant = rst ? '0 : grant_c;
        bus.add   = !rst && gnt_vld && !gnt_exit;
        bus.sub   = !rst && gnt_exit && (bus.cnt != '0);
        bus.full  = full_c;
        bus.err   = err_q;
    end
endmodule
